// File: rtl/man_pkg.sv
// Shared constants and state encoding for the Mandelbrot coordinate generator.
// Holds the default geometry and fixed-point width used by the sequencer, its interface and its accumulators.
package man_pkg;

  localparam int MAN_FPW  = 54;   // 2*27 fixed-point coordinate
  localparam int MAN_HRES = 800;
  localparam int MAN_VRES = 600;
  localparam int MAN_CW   = 10;
  localparam int MAN_AW   = 19;

  typedef enum logic [1:0] {
    MAN_CG_IDLE  = 2'd0,
    MAN_CG_RUN   = 2'd1,
    MAN_CG_DRAIN = 2'd2,
    MAN_CG_DONE  = 2'd3
  } man_cg_state_e;

endpackage

// File: rtl/man_coord_gen_if.sv
// Coordinate stream from the frame sequencer to the iteration engines.
// One pixel is transferred on each clock edge where out_vld and out_rdy are both high.
interface man_coord_gen_if
  import man_pkg::*;
#(
  parameter int FPW = MAN_FPW,
  parameter int CW  = MAN_CW,
  parameter int AW  = MAN_AW
);
  logic           out_vld;
  logic           out_rdy;
  logic [FPW-1:0] out_x;
  logic [FPW-1:0] out_y;
  logic [CW-1:0]  out_px;
  logic [CW-1:0]  out_py;
  logic [AW-1:0]  out_adr;

  modport master (
    output out_vld, out_x, out_y, out_px, out_py, out_adr,
    input  out_rdy
  );

  modport slave (
    input  out_vld, out_x, out_y, out_px, out_py, out_adr,
    output out_rdy
  );
endinterface

// File: rtl/man_coord_acc.sv
// Single-axis coordinate accumulator: reload from base, or add inc modulo 2^W.
// A load takes priority over a step when both are asserted in the same cycle.
module man_coord_acc
  import man_pkg::*;
#(
  parameter int W = MAN_FPW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] base,
  input  logic [W-1:0] inc,
  output logic [W-1:0] coord
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coord <= '0;
    end else if (load) begin
      coord <= base;
    end else if (step) begin
      coord <= coord + inc;
    end
  end

endmodule

// File: rtl/man_coord_gen.sv
// Frame sequencer: walks the HRES x VRES grid in raster order after a man_init edge,
// emitting one coordinate/address per handshake, then raises man_done once the engines are idle.
module man_coord_gen
  import man_pkg::*;
#(
  parameter int FPW  = MAN_FPW,
  parameter int HRES = MAN_HRES,
  parameter int VRES = MAN_VRES,
  parameter int CW   = MAN_CW,
  parameter int AW   = MAN_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            man_init,
  input  logic [FPW-1:0]  man_x0,
  input  logic [FPW-1:0]  man_y0,
  input  logic [FPW-1:0]  man_xs,
  input  logic [FPW-1:0]  man_ys,
  input  logic            eng_busy,
  output logic            man_done,
  man_coord_gen_if.master cg
);

  localparam logic [CW-1:0] PX_LAST = CW'(HRES - 1);
  localparam logic [CW-1:0] PY_LAST = CW'(VRES - 1);

  man_cg_state_e  state;
  man_cg_state_e  state_nxt;
  logic           init_d;
  logic           start;
  logic           accept;
  logic           xfer;
  logic           line_end;
  logic           last_px;
  logic [FPW-1:0] x0_q;
  logic [FPW-1:0] y0_q;
  logic [FPW-1:0] xs_q;
  logic [FPW-1:0] ys_q;
  logic           x_load;
  logic           x_step;
  logic           y_step;
  logic [FPW-1:0] x_base;

  assign start    = man_init & ~init_d;
  assign accept   = start & ((state == MAN_CG_IDLE) | (state == MAN_CG_DONE));
  assign xfer     = cg.out_vld & cg.out_rdy;
  assign line_end = (cg.out_px == PX_LAST);
  assign last_px  = line_end & (cg.out_py == PY_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MAN_CG_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MAN_CG_IDLE, MAN_CG_DONE: if (start) state_nxt = MAN_CG_RUN;
      MAN_CG_RUN:               if (xfer && last_px) state_nxt = MAN_CG_DRAIN;
      MAN_CG_DRAIN:             if (!eng_busy) state_nxt = MAN_CG_DONE;
      default:                  state_nxt = MAN_CG_IDLE;
    endcase
  end

  // Valid and done are pure state decodes, so reset clears them asynchronously.
  always_comb begin
    cg.out_vld = (state == MAN_CG_RUN);
    man_done   = (state == MAN_CG_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_d     <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      cg.out_px  <= '0;
      cg.out_py  <= '0;
      cg.out_adr <= '0;
    end else begin
      init_d <= man_init;
      if (accept) begin
        x0_q       <= man_x0;
        y0_q       <= man_y0;
        xs_q       <= man_xs;
        ys_q       <= man_ys;
        cg.out_px  <= '0;
        cg.out_py  <= '0;
        cg.out_adr <= '0;
      end else if (xfer && !last_px) begin
        cg.out_adr <= cg.out_adr + 1'b1;
        if (line_end) begin
          cg.out_px <= '0;
          cg.out_py <= cg.out_py + 1'b1;
        end else begin
          cg.out_px <= cg.out_px + 1'b1;
        end
      end
    end
  end

  // x reloads from the live register on a start (snapshot happens the same edge), else from the snapshot.
  always_comb begin
    x_load = accept | (xfer & line_end & ~last_px);
    x_step = xfer & ~line_end;
    y_step = xfer & line_end & ~last_px;
    x_base = accept ? man_x0 : x0_q;
  end

  man_coord_acc #(.W(FPW)) u_acc_x (
    .clk   (clk),
    .rst   (rst),
    .load  (x_load),
    .step  (x_step),
    .base  (x_base),
    .inc   (xs_q),
    .coord (cg.out_x)
  );

  man_coord_acc #(.W(FPW)) u_acc_y (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (y_step),
    .base  (man_y0),
    .inc   (ys_q),
    .coord (cg.out_y)
  );

endmodule
